level_sequencer: RTL
====================

Name: level_sequencer

Overview:
- Top-level game-flow FSM that sequences level transitions around the existing level-init controller and entity modules.
- Selects the current level number and issues a one-cycle load pulse so entities latch their level init states.
- Freezes physics outside active play and drives a fade level to the VGA pixel path for fade-out/fade-in between levels.
- Handles level-win (advance, wrap after last level) and player-death (restart same level) through the same hold/fade/load sequence.

Parameters:
- NUM_LEVELS, 4, number of levels; level_num wraps to 0 after NUM_LEVELS-1.
- HOLD_FRAMES, 30, frame_ticks spent frozen in HOLD after a win/death event before fading.
- FRAMES_PER_STEP, 2, frame_ticks per one-unit fade change.

Ports:
- sim_clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset; clock sim_clk.
- frame_tick  input  1  one-cycle pulse per video frame.
- player_win  input  1  level-complete event (level or pulse; sampled only in PLAY).
- player_dead  input  1  player-death event (sampled only in PLAY).
- level_num  output  3  current level index, 0..NUM_LEVELS-1.
- load_level  output  1  one-cycle pulse; entities latch init state for level_num.
- freeze  output  1  high = physics/entity updates halted.
- fade  output  3  0 = full brightness, 7 = black.
- win_count  output  8  levels completed since reset, saturates at 255.
- state_dbg  output  3  current FSM state encoding.

Behaviour:
- All outputs registered. Reset values: state=LOAD, level_num=0, load_level=0, freeze=1, fade=7, win_count=0, advance=0, counters=0.
- States: LOAD, FADE_IN, PLAY, HOLD, FADE_OUT.
- LOAD:
  - Lasts one cycle, then goes to FADE_IN.
  - load_level=1 for exactly the cycle after the LOAD→FADE_IN edge.
  - level_num is already valid during that pulse.
- FADE_IN:
  - Decrement fade by 1 every FRAMES_PER_STEP frame_ticks.
  - On the edge where fade becomes 0, go to PLAY and set freeze=0 on the same edge.
- PLAY:
  - player_win has priority over player_dead when both are high.
  - On either event: go to HOLD, set freeze=1 on the next edge, set advance=1 for win or 0 for death.
  - On win, also increment win_count (saturating).
- HOLD:
  - Count HOLD_FRAMES frame_ticks, then go to FADE_OUT.
  - win/dead are ignored here and in every state other than PLAY.
- FADE_OUT:
  - Increment fade by 1 every FRAMES_PER_STEP frame_ticks.
  - On the edge where fade becomes 7, go to LOAD.
  - On that same edge update level_num: if advance and level_num==NUM_LEVELS-1, set 0; if advance otherwise, set level_num+1; if not advance, leave unchanged.
- Frame/step counter:
  - Width clog2(max(HOLD_FRAMES,FRAMES_PER_STEP))+1.
  - Cleared on every state change.
  - Advances only on frame_tick; cycles without frame_tick hold all counters and fade.
- reset mid-sequence (any state) returns to the reset values and replays LOAD with level_num=0.
- fade never leaves the range 0..7; freeze=0 only in PLAY.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants (LOAD=0, FADE_IN=1, PLAY=2, HOLD=3, FADE_OUT=4);
  - FADE_MAX=7;
  - level_num width (3).
- One natural sub-module, tick_divider: counts frame_ticks and emits a one-cycle done pulse after N ticks, with clear input. It is instantiated once and reloaded per state with HOLD_FRAMES or FRAMES_PER_STEP.

Test Plan (NUM_LEVELS=4, HOLD_FRAMES=2, FRAMES_PER_STEP=1):
1. Reset for 3 cycles, then release; frame_tick every 4 cycles:
   - load_level pulses once with level_num=0.
   - fade steps 7→0 over 7 frame_ticks.
   - freeze falls on the same edge fade reaches 0.
   - state_dbg=2.
2. Pulse player_win in PLAY:
   - freeze=1 next cycle; win_count=1.
   - After 2 ticks, FADE_OUT; fade reaches 7 after 7 more ticks.
   - LOAD then load_level pulse with level_num=1.
3. Pulse player_dead in PLAY on level 1:
   - Same hold/fade timing; level_num stays 1 at the load_level pulse.
   - win_count unchanged.
4. Assert player_win and player_dead on the same cycle:
   - Treated as win: level_num increments and win_count increments.
5. Win on level_num=3:
   - level_num wraps to 0 at the load_level pulse.
   - Then hold player_win high through HOLD and FADE_OUT: win_count increments only once.
6. Assert reset during FADE_OUT with fade=4 on level 2:
   - Next cycle fade=7, level_num=0, win_count=0, freeze=1.
   - load_level pulses one cycle after release.

Source files
------------

// File: rtl/level_sequencer_pkg.sv
// Shared definitions for the level sequencer: state encoding, fade range and level index width.
package level_sequencer_pkg;

    localparam int         LEVEL_W  = 3;
    localparam logic [2:0] FADE_MAX = 3'd7;

    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_FADE_IN  = 3'd1,
        ST_PLAY     = 3'd2,
        ST_HOLD     = 3'd3,
        ST_FADE_OUT = 3'd4
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Game-flow signal bundle between the game logic (master) and the level sequencer (slave).
interface level_sequencer_if;
    import level_sequencer_pkg::*;

    logic               frame_tick;
    logic               player_win;
    logic               player_dead;
    logic [LEVEL_W-1:0] level_num;
    logic               load_level;
    logic               freeze;
    logic [2:0]         fade;
    logic [7:0]         win_count;
    logic [2:0]         state_dbg;

    modport master (
        output frame_tick, player_win, player_dead,
        input  level_num, load_level, freeze, fade, win_count, state_dbg
    );

    modport slave (
        input  frame_tick, player_win, player_dead,
        output level_num, load_level, freeze, fade, win_count, state_dbg
    );

endinterface

// File: rtl/level_sequencer_tick_divider.sv
// Frame-tick divider: counts ticks since the last clear and pulses done_o on the n_i-th tick.
// done_o is combinational from the registered count so the caller can act on the same edge.
module tick_divider #(
    parameter int CNT_W = 6
) (
    input  logic             sim_clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] n_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_o = tick_i && (cnt_q == n_i - CNT_W'(1));

    // Next count: clear wins, otherwise advance on tick and wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge sim_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// Game-flow sequencer: load level, fade in, play, hold after win/death, fade out, repeat.
module level_sequencer
    import level_sequencer_pkg::*;
#(
    parameter int NUM_LEVELS      = 4,
    parameter int HOLD_FRAMES     = 30,
    parameter int FRAMES_PER_STEP = 2
) (
    input logic         sim_clk,
    input logic         reset,
    level_sequencer_if.slave seq_if
);

    localparam int                 CNT_W      = $clog2(max_int(HOLD_FRAMES, FRAMES_PER_STEP)) + 1;
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

    seq_state_e         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               load_q, load_d;
    logic               freeze_q, freeze_d;
    logic [2:0]         fade_q, fade_d;
    logic [7:0]         win_cnt_q, win_cnt_d;
    logic               advance_q, advance_d;

    logic [CNT_W-1:0]   step_n;
    logic               step_clear;
    logic               step_done;

    // HOLD waits a long interval; both fade states step once per short interval.
    assign step_n     = (state_q == ST_HOLD) ? CNT_W'(HOLD_FRAMES) : CNT_W'(FRAMES_PER_STEP);
    assign step_clear = (state_d != state_q);

    tick_divider #(.CNT_W(CNT_W)) u_tick_div (
        .sim_clk (sim_clk),
        .reset   (reset),
        .clear_i (step_clear),
        .tick_i  (seq_if.frame_tick),
        .n_i     (step_n),
        .done_o  (step_done)
    );

    // Next-state and registered-output logic for the level flow.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        load_d    = 1'b0;
        fade_d    = fade_q;
        win_cnt_d = win_cnt_q;
        advance_d = advance_q;
        unique case (state_q)
            ST_LOAD: begin
                state_d = ST_FADE_IN;
                load_d  = 1'b1;
            end
            ST_FADE_IN: begin
                if (step_done) begin
                    if (fade_q <= 3'd1) begin
                        fade_d  = 3'd0;
                        state_d = ST_PLAY;
                    end else begin
                        fade_d = fade_q - 3'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (seq_if.player_win) begin
                    state_d   = ST_HOLD;
                    advance_d = 1'b1;
                    if (win_cnt_q != 8'hFF) begin
                        win_cnt_d = win_cnt_q + 8'd1;
                    end
                end else if (seq_if.player_dead) begin
                    state_d   = ST_HOLD;
                    advance_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (step_done) begin
                    state_d = ST_FADE_OUT;
                end
            end
            ST_FADE_OUT: begin
                if (step_done) begin
                    if (fade_q >= FADE_MAX - 3'd1) begin
                        fade_d  = FADE_MAX;
                        state_d = ST_LOAD;
                        if (advance_q) begin
                            level_d = (level_q == LAST_LEVEL) ? '0 : level_q + LEVEL_W'(1);
                        end
                    end else begin
                        fade_d = fade_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        freeze_d = (state_d != ST_PLAY);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge sim_clk) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            level_q   <= '0;
            load_q    <= 1'b0;
            freeze_q  <= 1'b1;
            fade_q    <= FADE_MAX;
            win_cnt_q <= 8'd0;
            advance_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            load_q    <= load_d;
            freeze_q  <= freeze_d;
            fade_q    <= fade_d;
            win_cnt_q <= win_cnt_d;
            advance_q <= advance_d;
        end
    end

    assign seq_if.level_num  = level_q;
    assign seq_if.load_level = load_q;
    assign seq_if.freeze     = freeze_q;
    assign seq_if.fade       = fade_q;
    assign seq_if.win_count  = win_cnt_q;
    assign seq_if.state_dbg  = state_q;

endmodule
